// File: rtl/keyin_pkg.sv
// Shared constants and types for the 4x4 keypad scanner.
// Key codes are {column, row}.
package keyin_pkg;

    localparam int KEY_COLS = 4;
    localparam int KEY_ROWS = 4;

    typedef logic [3:0] key_code_t;
    typedef logic [1:0] col_t;

endpackage

// File: rtl/key_fifo.sv
// Key-event queue with valid/ready head; a push into a full queue
// is accepted only when the head is popped on the same edge.
module key_fifo
    import keyin_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [3:0] push_code,
    output logic       full,
    output logic       out_valid,
    output logic [3:0] out_code,
    input  logic       out_ready
);

    localparam int AW = $clog2(DEPTH);

    key_code_t [DEPTH-1:0] mem;
    logic [AW-1:0]         rptr;
    logic [AW-1:0]         wptr;
    logic [AW:0]           count;
    logic                  pop;
    logic                  wr;

    assign out_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = out_valid & out_ready;
    assign wr        = push & (~full | pop);
    assign out_code  = out_valid ? mem[rptr] : 4'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem   <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= push_code;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({wr, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keyin_scan.sv
// 4x4 keypad scanner: column strobe, row synchroniser, per-key
// debounce over whole scans, and press events queued as key codes.
module keyin_scan
    import keyin_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 16,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [3:0]  col_drive,
    input  logic [3:0]  row_sense,
    output logic        key_valid,
    output logic [3:0]  key_code,
    input  logic        key_ready,
    output logic [15:0] key_state,
    output logic        key_overflow,
    input  logic        ovf_clear
);

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       raw;
    col_t             col;
    col_t             col_nxt;
    logic [7:0]       dcnt;
    logic             sample;
    logic [15:0]      stable;
    logic [15:0]      stable_n;
    logic [15:0][3:0] cnt;
    logic [15:0][3:0] cnt_n;
    logic [3:0]       rise;
    logic [3:0]       pend;
    col_t             pcol;
    logic [1:0]       lo_row;
    logic [3:0]       k;
    logic             push;
    key_code_t        push_code;
    logic             full;
    logic             drop;

    assign raw       = ~sync2;
    assign sample    = (dcnt == 8'(SETTLE_CYCLES - 1));
    assign col_nxt   = sample ? col + 2'd1 : col;
    assign key_state = stable;
    assign push      = |pend;
    assign push_code = {pcol, lo_row};
    assign drop      = push & full & ~(key_valid & key_ready);

    always_comb begin
        stable_n = stable;
        cnt_n    = cnt;
        rise     = '0;
        k        = '0;
        for (int r = 0; r < KEY_ROWS; r++) begin
            k = {col, 2'(r)};
            if (raw[r] == stable[k]) begin
                cnt_n[k] = '0;
            end else if (cnt[k] == 4'(DEBOUNCE_SCANS - 1)) begin
                stable_n[k] = raw[r];
                cnt_n[k]    = '0;
                rise[r]     = raw[r];
            end else begin
                cnt_n[k] = cnt[k] + 4'd1;
            end
        end
    end

    // Lowest pending row drains first, giving ascending row order.
    always_comb begin
        lo_row = 2'd0;
        for (int r = KEY_ROWS - 1; r >= 0; r--) begin
            if (pend[r]) lo_row = 2'(r);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1        <= 4'hF;
            sync2        <= 4'hF;
            col          <= '0;
            dcnt         <= '0;
            col_drive    <= 4'b1110;
            stable       <= '0;
            cnt          <= '0;
            pend         <= '0;
            pcol         <= '0;
            key_overflow <= 1'b0;
        end else begin
            sync1     <= row_sense;
            sync2     <= sync1;
            col       <= col_nxt;
            dcnt      <= sample ? 8'd0 : dcnt + 8'd1;
            col_drive <= ~(4'b0001 << col_nxt);
            if (sample) begin
                stable <= stable_n;
                cnt    <= cnt_n;
                pend   <= rise;
                pcol   <= col;
            end else if (push) begin
                pend <= pend & ~(4'b0001 << lo_row);
            end
            if (drop) begin
                key_overflow <= 1'b1;
            end else if (ovf_clear) begin
                key_overflow <= 1'b0;
            end
        end
    end

    key_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_code (push_code),
        .full      (full),
        .out_valid (key_valid),
        .out_code  (key_code),
        .out_ready (key_ready)
    );

endmodule
